// File: rtl/prio_queue_pkg.sv
// Shared defaults and entry layout for the patient-room priority queue.
// Optional feature macro: PRIOQ_AGING_EN adds a per-entry age field.
package prio_queue_pkg;

   localparam int PQ_DATA_W     = 4;
   localparam int PQ_PRIO_W     = 2;
   localparam int PQ_DEPTH      = 16;
   localparam int PQ_AGE_PERIOD = 64;

   // Occupancy counter must represent 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   localparam int PQ_CNT_W = cnt_width(PQ_DEPTH);

`ifdef PRIOQ_AGING_EN
   localparam int PQ_AGE_W = $clog2(PQ_AGE_PERIOD);
   typedef struct packed {
      logic                 valid;
      logic [PQ_PRIO_W-1:0] prio;
      logic [PQ_DATA_W-1:0] data;
      logic [PQ_AGE_W-1:0]  age;
   } pq_entry_t;
`else
   typedef struct packed {
      logic                 valid;
      logic [PQ_PRIO_W-1:0] prio;
      logic [PQ_DATA_W-1:0] data;
   } pq_entry_t;
`endif

endpackage

// File: rtl/prio_select.sv
// Combinational argmax over the queue slots, built as a binary tree.
// Leaves are padded to a power of two; on equal priority the lower index wins,
// which together with arrival-ordered storage gives oldest-first issue.
module prio_select
   import prio_queue_pkg::*;
#(
   parameter int PRIO_W = PQ_PRIO_W,
   parameter int DEPTH  = PQ_DEPTH
) (
   input  logic [DEPTH-1:0]        valid_i,
   input  logic [DEPTH*PRIO_W-1:0] prio_i,
   output logic [$clog2(DEPTH)-1:0] idx_o,
   output logic                    found_o
);

   localparam int LVL = $clog2(DEPTH);
   localparam int N   = 1 << LVL;

   // Heap layout: node k has children 2k and 2k+1, leaves at N..2N-1, root at 1.
   logic              node_f [2*N];
   logic [PRIO_W-1:0] node_p [2*N];
   logic [LVL-1:0]    node_i [2*N];

   assign node_f[0] = 1'b0;
   assign node_p[0] = '0;
   assign node_i[0] = '0;

   for (genvar k = 0; k < N; k++) begin : g_leaf
      if (k < DEPTH) begin : g_real
         assign node_f[N+k] = valid_i[k];
         assign node_p[N+k] = prio_i[k*PRIO_W +: PRIO_W];
      end else begin : g_pad
         assign node_f[N+k] = 1'b0;
         assign node_p[N+k] = '0;
      end
      assign node_i[N+k] = LVL'(k);
   end

   for (genvar k = 1; k < N; k++) begin : g_node
      logic take_r;
      // Right child wins only when strictly more urgent, so ties keep the lower index.
      assign take_r    = node_f[2*k+1] && (!node_f[2*k] || (node_p[2*k+1] > node_p[2*k]));
      assign node_f[k] = node_f[2*k] | node_f[2*k+1];
      assign node_p[k] = take_r ? node_p[2*k+1] : node_p[2*k];
      assign node_i[k] = take_r ? node_i[2*k+1] : node_i[2*k];
   end

   assign found_o = node_f[1];
   assign idx_o   = node_i[1];

endmodule

// File: rtl/prio_queue_pq.sv
// Parametrised priority queue: arrival-ordered compacted storage, argmax issue
// with oldest-first tie break, registered dequeue output and sticky error flags.
// Optional feature macro: PRIOQ_AGING_EN (per-slot age counters raise priority).
module prio_queue_pq
   import prio_queue_pkg::*;
#(
   parameter int DATA_W     = PQ_DATA_W,
   parameter int PRIO_W     = PQ_PRIO_W,
   parameter int DEPTH      = PQ_DEPTH,
   parameter int AGE_PERIOD = PQ_AGE_PERIOD
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enq_valid,
   input  logic [DATA_W-1:0]          enq_data,
   input  logic [PRIO_W-1:0]          enq_prio,
   output logic                       enq_ready,
   input  logic                       deq_req,
   output logic                       deq_valid,
   output logic [DATA_W-1:0]          deq_data,
   output logic [PRIO_W-1:0]          deq_prio,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       err_overflow,
   output logic                       err_underflow
);

   localparam int CNT_W = cnt_width(DEPTH);
   localparam int IDX_W = $clog2(DEPTH);

   if (DEPTH < 2 || AGE_PERIOD < 2) begin : g_bad_params
      $error("prio_queue_pq: DEPTH and AGE_PERIOD must both be at least 2");
   end

`ifdef PRIOQ_AGING_EN
   localparam int AGE_W = $clog2(AGE_PERIOD);
   typedef struct packed {
      logic              valid;
      logic [PRIO_W-1:0] prio;
      logic [DATA_W-1:0] data;
      logic [AGE_W-1:0]  age;
   } entry_t;
`else
   typedef struct packed {
      logic              valid;
      logic [PRIO_W-1:0] prio;
      logic [DATA_W-1:0] data;
   } entry_t;
`endif

   entry_t              slot_q [DEPTH];
   entry_t              slot_a [DEPTH];
   entry_t              slot_d [DEPTH];
   logic [CNT_W-1:0]    count_q, count_d;
   logic                deq_valid_q;
   logic [DATA_W-1:0]   deq_data_q;
   logic [PRIO_W-1:0]   deq_prio_q;
   logic                err_ovf_q, err_unf_q;

   logic                full_w, empty_w, do_enq, do_deq, found;
   logic [IDX_W-1:0]    sel_idx;
   logic [DEPTH-1:0]    valid_vec;
   logic [DEPTH*PRIO_W-1:0] prio_vec;

   assign full_w  = (count_q == CNT_W'(DEPTH));
   assign empty_w = (count_q == '0);
   assign do_enq  = enq_valid && !full_w;
   assign do_deq  = deq_req && !empty_w && found;

   // Flatten stored valid/priority for the selector (selection sees pre-existing entries only).
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         valid_vec[i]                   = slot_q[i].valid;
         prio_vec[i*PRIO_W +: PRIO_W]   = slot_q[i].prio;
      end
   end

   prio_select #(
      .PRIO_W (PRIO_W),
      .DEPTH  (DEPTH)
   ) u_select (
      .valid_i (valid_vec),
      .prio_i  (prio_vec),
      .idx_o   (sel_idx),
      .found_o (found)
   );

   // Advance age counters and bump saturating priority before the shift moves slots.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         slot_a[i] = slot_q[i];
`ifdef PRIOQ_AGING_EN
         if (slot_q[i].valid) begin
            if (slot_q[i].age == AGE_W'(AGE_PERIOD - 1)) begin
               slot_a[i].age = '0;
               if (slot_q[i].prio != '1) slot_a[i].prio = slot_q[i].prio + 1'b1;
            end else begin
               slot_a[i].age = slot_q[i].age + 1'b1;
            end
         end
`endif
      end
   end

   // Close the gap left by the issued slot, then append the new entry at the tail.
   always_comb begin
      int src;
      int wpos;
      wpos = int'(count_q) - (do_deq ? 1 : 0);
      for (int i = 0; i < DEPTH; i++) begin
         src = (do_deq && (i >= int'(sel_idx))) ? i + 1 : i;
         if (src < DEPTH) slot_d[i] = slot_a[src];
         else             slot_d[i] = '0;
         if (do_enq && (i == wpos)) begin
            slot_d[i]       = '0;
            slot_d[i].valid = 1'b1;
            slot_d[i].prio  = enq_prio;
            slot_d[i].data  = enq_data;
         end
      end
   end

   // Occupancy update; simultaneous enq+deq leaves it unchanged.
   always_comb begin
      count_d = count_q;
      if (do_enq && !do_deq)      count_d = count_q + 1'b1;
      else if (!do_enq && do_deq) count_d = count_q - 1'b1;
   end

   // State register: storage, occupancy, issue register and sticky errors.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) slot_q[i].valid <= 1'b0;
         count_q     <= '0;
         deq_valid_q <= 1'b0;
         deq_data_q  <= '0;
         deq_prio_q  <= '0;
         err_ovf_q   <= 1'b0;
         err_unf_q   <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
         count_q     <= count_d;
         deq_valid_q <= do_deq;
         if (do_deq) begin
            deq_data_q <= slot_q[sel_idx].data;
            deq_prio_q <= slot_q[sel_idx].prio;
         end
         if (enq_valid && full_w) err_ovf_q <= 1'b1;
         if (deq_req && empty_w)  err_unf_q <= 1'b1;
      end
   end

   assign enq_ready     = !full_w;
   assign full          = full_w;
   assign empty         = empty_w;
   assign count         = count_q;
   assign deq_valid     = deq_valid_q;
   assign deq_data      = deq_data_q;
   assign deq_prio      = deq_prio_q;
   assign err_overflow  = err_ovf_q;
   assign err_underflow = err_unf_q;

endmodule

// File: tb/tb_prio_queue_pq.sv
// Directed bench for prio_queue_pq in its default build (DEPTH=16, DATA_W=4, PRIO_W=2).
module tb_prio_queue_pq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enq_valid;
   logic [3:0] enq_data;
   logic [1:0] enq_prio;
   logic       enq_ready;
   logic       deq_req;
   logic       deq_valid;
   logic [3:0] deq_data;
   logic [1:0] deq_prio;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       err_overflow;
   logic       err_underflow;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   prio_queue_pq dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enq_valid     (enq_valid),
      .enq_data      (enq_data),
      .enq_prio      (enq_prio),
      .enq_ready     (enq_ready),
      .deq_req       (deq_req),
      .deq_valid     (deq_valid),
      .deq_data      (deq_data),
      .deq_prio      (deq_prio),
      .full          (full),
      .empty         (empty),
      .count         (count),
      .err_overflow  (err_overflow),
      .err_underflow (err_underflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic [3:0] d, input logic [1:0] p);
      enq_valid = 1'b1;
      enq_data  = d;
      enq_prio  = p;
      step();
      enq_valid = 1'b0;
   endtask

   // Request one issue, check the registered result, then check the pulse drops and data holds.
   task automatic deq_chk(input string tag, input logic [3:0] d, input logic [1:0] p);
      deq_req = 1'b1;
      step();
      deq_req = 1'b0;
      check({tag, "_valid"}, 32'(deq_valid), 1);
      check({tag, "_data"},  32'(deq_data),  32'(d));
      check({tag, "_prio"},  32'(deq_prio),  32'(p));
      step();
      check({tag, "_pulse"}, 32'(deq_valid), 0);
      check({tag, "_hold"},  32'(deq_data),  32'(d));
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_count"},   32'(count),         0);
      check({tag, "_empty"},   32'(empty),         1);
      check({tag, "_full"},    32'(full),          0);
      check({tag, "_ready"},   32'(enq_ready),     1);
      check({tag, "_dvalid"},  32'(deq_valid),     0);
      check({tag, "_ddata"},   32'(deq_data),      0);
      check({tag, "_dprio"},   32'(deq_prio),      0);
      check({tag, "_ovf"},     32'(err_overflow),  0);
      check({tag, "_unf"},     32'(err_underflow), 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      enq_valid = 1'b0;
      enq_data  = '0;
      enq_prio  = '0;
      deq_req   = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      check_reset_state("rst");

      // Priority ordering: 2 (p3), 3 (p1), 1 (p0).
      enq(4'd1, 2'd0);
      enq(4'd2, 2'd3);
      enq(4'd3, 2'd1);
      check("cnt3", 32'(count), 3);
      check("nonempty", 32'(empty), 0);
      deq_chk("prio_a", 4'd2, 2'd3);
      deq_chk("prio_b", 4'd3, 2'd1);
      deq_chk("prio_c", 4'd1, 2'd0);
      check("cnt0", 32'(count), 0);

      // Equal priority issues in arrival order.
      enq(4'd5, 2'd2);
      enq(4'd6, 2'd2);
      enq(4'd7, 2'd2);
      deq_chk("fifo_a", 4'd5, 2'd2);
      deq_chk("fifo_b", 4'd6, 2'd2);
      deq_chk("fifo_c", 4'd7, 2'd2);
      check("empty_again", 32'(empty), 1);

      // Dequeue while empty: no issue, data held, sticky underflow.
      deq_req = 1'b1;
      step();
      deq_req = 1'b0;
      check("unf_valid", 32'(deq_valid), 0);
      check("unf_data", 32'(deq_data), 7);
      check("unf_flag", 32'(err_underflow), 1);
      check("unf_cnt", 32'(count), 0);

      // Fill: data i, priority 3 for i=4, 2 for even, 1 for odd.
      for (int i = 0; i < 16; i++) begin
         enq(4'(i), (i == 4) ? 2'd3 : ((i % 2 == 0) ? 2'd2 : 2'd1));
      end
      check("fill_cnt", 32'(count), 16);
      check("fill_full", 32'(full), 1);
      check("fill_ready", 32'(enq_ready), 0);
      check("fill_ovf0", 32'(err_overflow), 0);

      enq(4'd15, 2'd3);
      check("ovf_flag", 32'(err_overflow), 1);
      check("ovf_cnt", 32'(count), 16);

      // Enq while full together with deq: enq dropped (not ready), oldest p3 (d=4) issued.
      enq_valid = 1'b1;
      enq_data  = 4'd9;
      enq_prio  = 2'd3;
      deq_req   = 1'b1;
      step();
      enq_valid = 1'b0;
      deq_req   = 1'b0;
      check("fullmix_valid", 32'(deq_valid), 1);
      check("fullmix_data", 32'(deq_data), 4);
      check("fullmix_prio", 32'(deq_prio), 3);
      check("fullmix_cnt", 32'(count), 15);
      check("fullmix_ovf", 32'(err_overflow), 1);

      // Legal simultaneous enq+deq: issues oldest p2 (d=0), new d=9 p3 not considered.
      enq_valid = 1'b1;
      enq_data  = 4'd9;
      enq_prio  = 2'd3;
      deq_req   = 1'b1;
      step();
      enq_valid = 1'b0;
      deq_req   = 1'b0;
      check("mix_valid", 32'(deq_valid), 1);
      check("mix_data", 32'(deq_data), 0);
      check("mix_prio", 32'(deq_prio), 2);
      check("mix_cnt", 32'(count), 15);
      step();
      deq_chk("after_mix", 4'd9, 2'd3);
      deq_chk("next_p2", 4'd2, 2'd2);
      check("cnt13", 32'(count), 13);
      check("unf_sticky", 32'(err_underflow), 1);

      // Reset mid-stream discards everything and clears flags.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check_reset_state("midrst");

      // Queue works again after reset.
      enq(4'd11, 2'd1);
      deq_chk("post_rst", 4'd11, 2'd1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
